// File: rtl/car_speed_cntl.sv
// Four-level car speed controller: a Moore FSM stepping STOP/SLOW/MEDIUM/FAST
// one level per clock edge from the pedals, with the ignition key as a synchronous reset.
module car_speed_cntl (
    input  logic       clock,
    input  logic       keys,
    input  logic       brake,
    input  logic       accelerate,
    output logic [1:0] speed
);

    typedef enum logic [1:0] {
        STOP   = 2'b00,
        SLOW   = 2'b01,
        MEDIUM = 2'b10,
        FAST   = 2'b11
    } speed_t;

    speed_t state;

    // Brake outranks the accelerator; both directions saturate at the end levels.
    always_ff @(posedge clock) begin
        if (!keys) begin
            state <= STOP;
        end else if (brake) begin
            case (state)
                FAST:    state <= MEDIUM;
                MEDIUM:  state <= SLOW;
                default: state <= STOP;
            endcase
        end else if (accelerate) begin
            case (state)
                STOP:    state <= SLOW;
                SLOW:    state <= MEDIUM;
                default: state <= FAST;
            endcase
        end
    end

    assign speed = state;

endmodule

// File: tb/tb_car_speed_cntl.sv
// Bench for car_speed_cntl: directed vector table, hand-written corner sequences,
// then random pedal/key traffic compared against an arithmetic level model.
module tb_car_speed_cntl;

    logic       clock;
    logic       keys;
    logic       brake;
    logic       accelerate;
    logic [1:0] speed;

    int passed;
    int total;
    int model_lvl;

    car_speed_cntl dut (
        .clock      (clock),
        .keys       (keys),
        .brake      (brake),
        .accelerate (accelerate),
        .speed      (speed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       k;
        logic       b;
        logic       a;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: speed=%b expected=%b at %0t", name, act, req, $time);
    endtask

    // Reference: speed as an integer level 0..3 with clamping arithmetic.
    task automatic model_step(input logic k, input logic b, input logic a);
        if (!k)     model_lvl = 0;
        else if (b) model_lvl = (model_lvl > 0) ? model_lvl - 1 : 0;
        else if (a) model_lvl = (model_lvl < 3) ? model_lvl + 1 : 3;
    endtask

    task automatic apply(input logic k, input logic b, input logic a);
        @(negedge clock);
        keys = k; brake = b; accelerate = a;
        @(posedge clock);
        model_step(k, b, a);
        #1;
    endtask

    task automatic add(input logic k, input logic b, input logic a, input logic [1:0] e);
        vec_t v;
        v.k = k; v.b = b; v.a = a; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        passed = 0;
        total = 0;
        model_lvl = 0;
        keys = 1'b0; brake = 1'b0; accelerate = 1'b0;

        // Reset, then key-off with accelerator held
        add(0,0,0,2'b00);
        add(0,0,1,2'b00); add(0,0,1,2'b00); add(0,0,1,2'b00);
        // Accelerate and saturate
        add(1,0,1,2'b01); add(1,0,1,2'b10); add(1,0,1,2'b11); add(1,0,1,2'b11);
        // Down to MEDIUM, then brake with accelerator held
        add(1,1,0,2'b10);
        add(1,1,1,2'b01); add(1,1,1,2'b00); add(1,1,1,2'b00);
        // Hold at SLOW, then accelerate
        add(1,0,1,2'b01); add(1,0,0,2'b01);
        add(1,0,1,2'b10); add(1,0,1,2'b11); add(1,0,1,2'b11);
        // Decelerate and saturate
        add(1,1,0,2'b10); add(1,1,0,2'b01); add(1,1,0,2'b00);
        add(1,1,0,2'b00); add(1,1,0,2'b00);
        // Key-off at FAST, then resume from STOP
        add(1,0,1,2'b01); add(1,0,1,2'b10); add(1,0,1,2'b11);
        add(0,0,1,2'b00); add(1,0,1,2'b01);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].k, vecs[i].b, vecs[i].a);
            check($sformatf("vec%0d", i), speed, vecs[i].exp);
        end

        // Pulse between edges must be ignored
        apply(1,0,0);
        check("hold_before_pulse", speed, 2'b01);
        @(negedge clock);
        accelerate = 1'b1;
        #2 accelerate = 1'b0;
        brake = 1'b1;
        #1 brake = 1'b0;
        @(posedge clock);
        model_step(1,0,0);
        #1;
        check("pulse_ignored", speed, 2'b01);

        // No combinational path from inputs to speed
        apply(1,0,1);
        check("step_to_medium", speed, 2'b10);
        brake = 1'b1; keys = 1'b0;
        #2;
        check("no_comb_path", speed, 2'b10);

        // Key held low from each level goes straight to STOP
        for (int lvl = 0; lvl < 4; lvl++) begin
            apply(0,0,0);
            for (int j = 0; j < lvl; j++) apply(1,0,1);
            check($sformatf("climb%0d", lvl), speed, 2'(lvl));
            apply(0,1,1);
            check($sformatf("keyoff_from%0d", lvl), speed, 2'b00);
        end

        // Random traffic against the level model
        for (int i = 0; i < 400; i++) begin
            logic k, b, a;
            k = ($urandom_range(0, 7) != 0);
            b = $urandom_range(0, 2) == 0;
            a = $urandom_range(0, 1) == 1;
            apply(k, b, a);
            check($sformatf("rand%0d", i), speed, 2'(model_lvl));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
